// File: rtl/ddr_axi_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ddr_axi_pkg
// Desc     : Shared types and constants for the DDR write command path:
//            write-command FSM state encoding, AXI beat size and beat bytes.
// Revision : 1.0 - initial release
//==============================================================================
package ddr_axi_pkg;

    // AXI AxSIZE for 8-byte beats
    localparam int c_axi_size     = 3;
    localparam int c_data_width   = 64;
    localparam int c_beat_bytes   = c_data_width / 8;

    // Write-command FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_BUSY      = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6
    } wr_state_t;

    // Bytes carried by one data beat of the given width
    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_sync_fifo.sv
`default_nettype none
//==============================================================================
// Module   : ddr_sync_fifo
// Desc     : Single-clock first-word-fall-through FIFO. Head entry is visible
//            on rd_data whenever count is non-zero. Storage is not reset.
// Revision : 1.0 - initial release
//==============================================================================
module ddr_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         push_valid,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A push at full is dropped; a pop at empty is dropped
    assign w_push  = push_valid && !full;
    assign w_pop   = pop && !empty;

    assign full    = (r_count == c_cnt_w'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage write; contents deliberately left unreset
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_wr_cmd_gen.sv
`default_nettype none
//==============================================================================
// Module   : ddr_wr_cmd_gen
// Desc     : Splits a multi-burst user write command into single-burst
//            commands for a downstream AXI write engine, gating each burst
//            on enough buffered data in the write FIFO.
// Revision : 1.0 - initial release
//==============================================================================
module ddr_wr_cmd_gen
    import ddr_axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 29,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int NUM_BURST_WIDTH = 8,
    parameter int FIFO_DEPTH      = 512
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       usr_wr_req,
    output logic                       usr_wr_ack,
    input  logic [ADDR_WIDTH-1:0]      usr_wr_addr,
    input  logic [BURST_LEN_WIDTH-1:0] usr_wr_burst_len,
    input  logic [NUM_BURST_WIDTH-1:0] usr_wr_num_burst,
    output logic                       usr_wr_busy,
    output logic                       usr_wr_done,
    output logic                       usr_wr_err,
    input  logic [DATA_WIDTH-1:0]      usr_wr_data,
    input  logic                       usr_wr_data_valid,
    output logic                       usr_wr_data_ready,
    output logic                       wr_start,
    output logic [ADDR_WIDTH-1:0]      wr_start_addr,
    output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
    output logic [NUM_BURST_WIDTH-1:0] wr_num_burst,
    input  logic                       wr_ready,
    input  logic                       wr_done,
    output logic [DATA_WIDTH-1:0]      wr_fifo_rd_data,
    input  logic                       wr_fifo_rd_valid
);

    localparam int c_cnt_w          = $clog2(FIFO_DEPTH) + 1;
    localparam int c_bytes_per_beat = beat_bytes(DATA_WIDTH);

    wr_state_t                 r_state;
    wr_state_t                 w_next_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [BURST_LEN_WIDTH-1:0] r_burst_len;
    logic [NUM_BURST_WIDTH-1:0] r_num_burst;
    logic [NUM_BURST_WIDTH-1:0] r_remaining;
    logic                      r_err;
    logic [c_cnt_w-1:0]        w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [31:0]               w_len_ext;
    logic [31:0]               w_cnt_ext;
    logic [ADDR_WIDTH-1:0]     w_addr_step;
    logic                      w_len_too_big;
    logic                      w_err_set;

    ddr_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .push_data  (usr_wr_data),
        .push_valid (usr_wr_data_valid),
        .pop        (wr_fifo_rd_valid),
        .rd_data    (wr_fifo_rd_data),
        .count      (w_fifo_count),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty)
    );

    // Widen length/count to 32 bits so comparisons against FIFO_DEPTH are exact
    assign w_len_ext     = 32'(r_burst_len);
    assign w_cnt_ext     = 32'(w_fifo_count);
    assign w_len_too_big = (w_len_ext > 32'(FIFO_DEPTH));
    // Address advance per burst; truncation gives modulo-2^ADDR_WIDTH wrap
    assign w_addr_step   = ADDR_WIDTH'(w_len_ext * 32'(c_bytes_per_beat));
    assign w_err_set     = (wr_fifo_rd_valid && w_fifo_empty) ||
                           ((r_state == ST_CHECK) && (r_burst_len != '0) &&
                            (r_num_burst != '0) && w_len_too_big);

    assign usr_wr_busy       = (r_state != ST_IDLE);
    assign usr_wr_err        = r_err;
    assign usr_wr_data_ready = !w_fifo_full;
    assign wr_start_addr     = r_addr;
    assign wr_burst_len      = r_burst_len;
    assign wr_num_burst      = NUM_BURST_WIDTH'(1);

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; ISSUE holds until the engine is idle
    always_comb begin
        w_next_state = r_state;
        usr_wr_ack   = 1'b0;
        wr_start     = 1'b0;
        usr_wr_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                usr_wr_ack = 1'b1;
                if (usr_wr_req) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((r_burst_len == '0) || (r_num_burst == '0) || w_len_too_big) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if ((w_cnt_ext >= w_len_ext) && wr_ready) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_ready) begin
                    wr_start     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wr_done) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_remaining == NUM_BURST_WIDTH'(1)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                usr_wr_done  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command latch, per-burst address/remaining update and sticky error
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr      <= '0;
            r_burst_len <= '0;
            r_num_burst <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && usr_wr_req) begin
                r_addr      <= usr_wr_addr;
                r_burst_len <= usr_wr_burst_len;
                r_num_burst <= usr_wr_num_burst;
                r_remaining <= usr_wr_num_burst;
            end
            if (r_state == ST_NEXT) begin
                r_addr      <= r_addr + w_addr_step;
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ddr_wr_cmd_gen.md
DDR_WR_CMD_GEN -- requirements
Module: ddr_wr_cmd_gen

Interface
REQ-001 Param DATA_WIDTH, 64, data beat width (8-byte beats, AXI size 3).
REQ-002 Param ADDR_WIDTH, 29, byte address width.
REQ-003 Param BURST_LEN_WIDTH, 8, burst length field width (beats, 1-based).
REQ-004 Param NUM_BURST_WIDTH, 8, burst count field width.
REQ-005 Param FIFO_DEPTH, 512, write data FIFO entries, power of two.
REQ-006 ACLK  in  1  clock; all logic rising-edge.
REQ-007 ARESETN  in  1  reset, asynchronous, active-low.
REQ-008 usr_wr_req / usr_wr_ack  in/out  1/1  user command handshake; command accepted when both high.
REQ-009 usr_wr_addr / usr_wr_burst_len / usr_wr_num_burst  in  ADDR_WIDTH/BURST_LEN_WIDTH/NUM_BURST_WIDTH  start byte address, beats per burst, bursts per command.
REQ-010 usr_wr_busy / usr_wr_done / usr_wr_err  out  1/1/1  command active; one-cycle completion pulse; sticky error.
REQ-011 usr_wr_data / usr_wr_data_valid / usr_wr_data_ready  in/in/out  DATA_WIDTH/1/1  write data push; beat stored when valid and ready.
REQ-012 wr_start / wr_start_addr / wr_burst_len / wr_num_burst  out  1/ADDR_WIDTH/BURST_LEN_WIDTH/NUM_BURST_WIDTH  single-burst command to downstream AXI write engine; wr_num_burst fixed 1.
REQ-013 wr_ready / wr_done  in  1/1  engine idle; engine one-burst-complete pulse.
REQ-014 wr_fifo_rd_data / wr_fifo_rd_valid  out/in  DATA_WIDTH/1  FIFO head beat; pop strobe from engine (asserted on each accepted AXI W beat).

Function
REQ-015 FIFO: first-word-fall-through; wr_fifo_rd_data shows head entry whenever count > 0, next entry valid the cycle after a pop.
REQ-016 usr_wr_data_ready = (count < FIFO_DEPTH); push and pop in same cycle: both take effect, count unchanged; at full, push blocked, pop proceeds.
REQ-017 Pop with count == 0: ignored, count stays 0, usr_wr_err set.
REQ-018 FSM states: IDLE, CHECK, WAIT_DATA, ISSUE, BUSY, NEXT, DONE.
REQ-019 IDLE: usr_wr_ack = 1; on usr_wr_req, latch addr/burst_len/num_burst, remaining = num_burst, go CHECK.
REQ-020 CHECK: burst_len == 0 or num_burst == 0 -> DONE, no wr_start; burst_len > FIFO_DEPTH -> set usr_wr_err, DONE; else WAIT_DATA.
REQ-021 WAIT_DATA: when count >= burst_len and wr_ready -> ISSUE.
REQ-022 ISSUE: wr_start = 1 for exactly one cycle with wr_start_addr = current addr, wr_burst_len = latched burst_len; -> BUSY.
REQ-023 BUSY: on wr_done -> NEXT; wr_done outside BUSY ignored.
REQ-024 NEXT: addr += burst_len * (DATA_WIDTH/8), modulo 2^ADDR_WIDTH; remaining -= 1; remaining == 0 -> DONE else WAIT_DATA.
REQ-025 DONE: usr_wr_done = 1 for one cycle; -> IDLE.
REQ-026 usr_wr_busy = 1 in every state except IDLE; usr_wr_req outside IDLE ignored.
REQ-027 Issue-to-issue gap ≥ 3 cycles after wr_done (NEXT, WAIT_DATA, ISSUE); wr_start never asserted while wr_ready = 0.
REQ-028 FIFO push accepted in all states, including before command arrival.
REQ-029 usr_wr_err cleared only by reset.

Reset
REQ-030 ARESETN low: FSM IDLE, FIFO count 0, read/write pointers 0, wr_start 0, usr_wr_done 0, usr_wr_err 0, usr_wr_busy 0, usr_wr_ack 1 after release, wr_start_addr 0, wr_burst_len 0, usr_wr_data_ready 1.
REQ-031 Reset mid-command: command and FIFO contents discarded; no wr_start or usr_wr_done after release until new command.
REQ-032 FIFO storage array not reset; only pointers and count.

Structure
REQ-033 Shared package ddr_axi_pkg: FSM state encoding, AXI size constant 3, beat-byte constant DATA_WIDTH/8.
REQ-034 One sub-module ddr_sync_fifo (FWFT, parameterised width/depth, count, full, empty outputs); FSM and address arithmetic in ddr_wr_cmd_gen top.

Verification
REQ-035 Push 16 beats, cmd addr 0x1000, len 8, num 2 -> wr_start at 0x1000 len 8, then after wr_done at 0x1040 len 8, one usr_wr_done.
REQ-036 Cmd len 4 num 1 with FIFO empty -> no wr_start until 4th beat stored; data popped in push order.
REQ-037 Cmd len 0 -> usr_wr_done 2 cycles after accept, no wr_start, usr_wr_err 0.
REQ-038 Fill 512 beats -> usr_wr_data_ready 0; simultaneous push+pop at full -> count stays 512 minus 1, push rejected.
REQ-039 Cmd addr 0x1FFFFFC0, len 8, num 2 -> second burst at 0x00000000.
REQ-040 ARESETN low during BUSY -> all outputs at REQ-030 values, no usr_wr_done after release.
